// File: rtl/inst_mem_loader.sv
// Instruction-memory loader: receives a length-prefixed stream of big-endian
// 16-bit words, writes them to instruction memory and holds the CPU in reset
// until a complete program has been loaded.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   LEN_HI  | waiting (no timeout) for high byte of word count N
//   LEN_LO  | waiting for low byte of N, then range check
//   DATA_HI | waiting for high byte of the current word
//   DATA_LO | waiting for low byte; acceptance issues the write
//   DONE    | program loaded, CPU released; start restarts
//   ERROR   | oversize frame or inter-byte timeout; start restarts
module inst_mem_loader #(
  parameter int DEPTH          = 256,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        start,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_DONE, S_ERROR
  } state_t;

  localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  // The edge on which the idle count would reach TIMEOUT_CYCLES is the edge
  // that enters ERROR, so the compare looks one count early.
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]       DEPTH_W   = 17'(DEPTH);

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [7:0]          hi_q, hi_d;
  logic [15:0]         idx_q, idx_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                mem_we_q, mem_we_d;
  logic [15:0]         mem_addr_q, mem_addr_d;
  logic [15:0]         mem_data_q, mem_data_d;

  logic        accept;
  logic        timeout;
  logic        counting;
  logic        last_word;
  logic [15:0] len_word;

  assign accept    = byte_valid & byte_ready;
  assign counting  = (state_q == S_LEN_LO) || (state_q == S_DATA_HI) ||
                     (state_q == S_DATA_LO);
  assign timeout   = counting && (idle_q == IDLE_LAST) && !accept;
  assign last_word = (idx_q == len_q - 16'd1);
  assign len_word  = {hi_q, byte_in};

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;

  // State and datapath registers, async active-high reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_LEN_HI;
      len_q      <= '0;
      hi_q       <= '0;
      idx_q      <= '0;
      idle_q     <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      hi_q       <= hi_d;
      idx_q      <= idx_d;
      idle_q     <= idle_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Next-state logic; an accepted byte always beats a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN_HI:  if (accept) state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (len_word == 16'd0)                state_d = S_DONE;
          else if ({1'b0, len_word} > DEPTH_W)  state_d = S_ERROR;
          else                                  state_d = S_DATA_HI;
        end else if (timeout) state_d = S_ERROR;
      end
      S_DATA_HI: begin
        if (accept)       state_d = S_DATA_LO;
        else if (timeout) state_d = S_ERROR;
      end
      S_DATA_LO: begin
        if (accept)       state_d = last_word ? S_DONE : S_DATA_HI;
        else if (timeout) state_d = S_ERROR;
      end
      S_DONE, S_ERROR: if (start) state_d = S_LEN_HI;
      default:         state_d = S_LEN_HI;
    endcase
  end

  // Datapath: byte capture, word index, idle counter and memory write port.
  always_comb begin
    len_d      = len_q;
    hi_d       = hi_q;
    idx_d      = idx_q;
    idle_d     = idle_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (accept) idle_d = '0;
    else if (counting) idle_d = idle_q + 1'b1;
    case (state_q)
      S_LEN_HI:  if (accept) hi_d = byte_in;
      S_LEN_LO:  if (accept) len_d = len_word;
      S_DATA_HI: if (accept) hi_d = byte_in;
      S_DATA_LO: begin
        if (accept) begin
          mem_we_d   = 1'b1;
          mem_addr_d = idx_q;
          mem_data_d = len_word;
          if (!last_word) idx_d = idx_q + 16'd1;
        end
      end
      S_DONE, S_ERROR: begin
        if (start) begin
          idx_d  = '0;
          idle_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Status outputs decoded directly from the state register.
  always_comb begin
    byte_ready = 1'b0;
    cpu_reset  = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state_q)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: byte_ready = 1'b1;
      S_DONE: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
      end
      S_ERROR: error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: table of frames plus hand-written corner cases;
// expected memory writes go through a scoreboard queue checked by a monitor.
module tb_inst_mem_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        start;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        cpu_reset;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int writes_seen = 0;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        last;
  } wr_t;
  wr_t sb_q[$];

  typedef struct {
    int          nbytes;
    logic [63:0] bytes;
    int          gap;
    logic        exp_done;
    logic        exp_error;
    int          exp_writes;
  } vec_t;

  inst_mem_loader #(.DEPTH(256), .TIMEOUT_CYCLES(10)) dut (
    .clock(clock), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .start(start), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .cpu_reset(cpu_reset),
    .done(done), .error(error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every write must match the next scoreboard entry.
  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      writes_seen++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h with nothing expected",
                 mem_addr, mem_data);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_data, e.data);
        chk("wr_done", done, e.last);
        chk("wr_cpu_reset", cpu_reset, !e.last);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) @(posedge clock);
      #1;
    end
    byte_valid = 1'b1;
    byte_in    = b;
    n = 0;
    while (n < 50) begin
      @(negedge clock);
      if (byte_ready) break;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL byte_ready_wait: got 0 expected 1 within 50 cycles");
    end
    @(posedge clock);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [15:0] d, input logic last);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.last = last;
    sb_q.push_back(e);
  endtask

  // Sends a frame and, from the frame bytes alone, predicts the writes it causes.
  task automatic send_seq(input logic [63:0] bs, input int n, input int gap);
    int          nw;
    int          j;
    logic [7:0]  b;
    logic [7:0]  prev;
    nw   = int'({bs[63:56], bs[55:48]});
    prev = 8'h00;
    for (int k = 0; k < n; k++) begin
      b = bs[63-8*k -: 8];
      if (k >= 3 && (k % 2) == 1 && nw >= 1 && nw <= 256) begin
        j = (k - 3) / 2;
        push_wr(16'(j), {prev, b}, j == nw - 1);
      end
      send_byte(b, (k == 0) ? 0 : gap);
      prev = b;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  vec_t tbl[6];
  int   wb;

  initial begin
    tbl[0] = '{6, 64'h0002_1234_ABCD_0000, 0, 1'b1, 1'b0, 2};
    tbl[1] = '{4, 64'h0001_55AA_0000_0000, 2, 1'b1, 1'b0, 1};
    tbl[2] = '{4, 64'h0001_7788_0000_0000, 0, 1'b1, 1'b0, 1};
    tbl[3] = '{2, 64'h0000_0000_0000_0000, 0, 1'b1, 1'b0, 0};
    tbl[4] = '{2, 64'h0101_0000_0000_0000, 0, 1'b0, 1'b1, 0};
    tbl[5] = '{8, 64'h0003_DEAD_BEEF_0102, 1, 1'b1, 1'b0, 3};

    reset = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; start = 1'b0;
    repeat (2) tick();
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_byte_ready", byte_ready, 1);
    reset = 1'b0;
    repeat (30) tick();
    chk("len_hi_no_timeout", error, 0);
    chk("len_hi_ready", byte_ready, 1);

    for (int v = 0; v < 6; v++) begin
      wb = writes_seen;
      send_seq(tbl[v].bytes, tbl[v].nbytes, tbl[v].gap);
      chk($sformatf("v%0d_done", v), done, tbl[v].exp_done);
      chk($sformatf("v%0d_error", v), error, tbl[v].exp_error);
      chk($sformatf("v%0d_cpu_reset", v), cpu_reset, !tbl[v].exp_done);
      chk($sformatf("v%0d_ready", v), byte_ready, 0);
      repeat (3) tick();
      chk($sformatf("v%0d_writes", v), writes_seen - wb, tbl[v].exp_writes);
      chk($sformatf("v%0d_sb_empty", v), sb_q.size(), 0);
      chk($sformatf("v%0d_hold_done", v), done, tbl[v].exp_done);
      pulse_start();
      chk($sformatf("v%0d_restart_cpu_reset", v), cpu_reset, 1);
      chk($sformatf("v%0d_restart_ready", v), byte_ready, 1);
      chk($sformatf("v%0d_restart_done", v), done, 0);
      chk($sformatf("v%0d_restart_error", v), error, 0);
    end

    // Start ignored mid-load; byte arriving on the timeout edge wins.
    wb = writes_seen;
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    pulse_start();
    chk("start_ignored_ready", byte_ready, 1);
    chk("start_ignored_done", done, 0);
    push_wr(16'h0000, 16'h1234, 1'b1);
    send_byte(8'h12, 8);
    chk("byte_beats_timeout", error, 0);
    send_byte(8'h34, 0);
    chk("byte_beats_timeout_done", done, 1);
    tick();
    chk("byte_beats_timeout_writes", writes_seen - wb, 1);
    pulse_start();

    // Inter-byte timeout: ERROR exactly ten edges after the last accepted byte.
    wb = writes_seen;
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    repeat (9) tick();
    chk("timeout_not_yet", error, 0);
    tick();
    chk("timeout_error", error, 1);
    chk("timeout_cpu_reset", cpu_reset, 1);
    chk("timeout_ready", byte_ready, 0);
    chk("timeout_no_write", writes_seen - wb, 0);
    pulse_start();

    // Largest legal frame: N equal to DEPTH.
    wb = writes_seen;
    for (int j = 0; j < 256; j++) push_wr(16'(j), {8'(j), ~8'(j)}, j == 255);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    for (int j = 0; j < 256; j++) begin
      send_byte(8'(j), 0);
      send_byte(~8'(j), 0);
    end
    chk("full_depth_done", done, 1);
    tick();
    chk("full_depth_writes", writes_seen - wb, 256);
    chk("full_depth_sb_empty", sb_q.size(), 0);
    pulse_start();

    // Reset while in DATA_LO abandons the frame and clears all outputs at once.
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    reset = 1'b1;
    #1;
    chk("midrst_mem_we", mem_we, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_mem_data", mem_data, 0);
    chk("midrst_cpu_reset", cpu_reset, 1);
    chk("midrst_done", done, 0);
    chk("midrst_error", error, 0);
    chk("midrst_ready", byte_ready, 1);
    tick();
    reset = 1'b0;
    tick();
    wb = writes_seen;
    send_seq(64'h0001_0001_0000_0000, 4, 0);
    chk("after_rst_done", done, 1);
    tick();
    chk("after_rst_writes", writes_seen - wb, 1);
    chk("after_rst_sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
